// File: rtl/grid_erosion_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// grid_erosion_engine : row-serial erosion of an occupancy grid, single or
//                       repeated passes with per-pass / total removal counts
// Revision: 1.0
// ---------------------------------------------------------------------------
module grid_erosion_engine #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 16,
  parameter int THRESH     = 4,
  parameter int MAX_PASSES = 255
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 load_valid,
  output logic                                 load_ready,
  input  logic [WIDTH-1:0]                     load_row,
  input  logic                                 start,
  input  logic                                 single_pass,
  input  logic                                 clear,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 limit_hit,
  output logic [$clog2(WIDTH*DEPTH+1)-1:0]     pass_removed,
  output logic [$clog2(WIDTH*DEPTH+1)-1:0]     total_removed,
  output logic [$clog2(MAX_PASSES+1)-1:0]      pass_count,
  input  logic [$clog2(DEPTH)-1:0]             rd_addr,
  output logic [WIDTH-1:0]                     rd_data
);

  localparam int CW = $clog2(WIDTH*DEPTH+1);
  localparam int PW = $clog2(MAX_PASSES+1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ROW = AW'(DEPTH-1);
  localparam logic [AW:0]   DEPTH_L  = (AW+1)'(DEPTH);
  localparam logic [PW-1:0] MAXP     = PW'(MAX_PASSES);
  localparam logic [3:0]    TH       = 4'(THRESH);

  typedef enum logic [1:0] {S_IDLE, S_READY, S_SWEEP, S_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] grid [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    row_ptr;
  logic [WIDTH-1:0] prev_row;
  logic [CW-1:0]    acc;
  logic             sp_latched;

  logic [WIDTH-1:0] cur_row, next_row, removed, new_row;
  logic [WIDTH+1:0] prev_pad, cur_pad, next_pad;
  logic [3:0]       cnt;
  logic [CW-1:0]    row_pop, acc_total;
  logic             last_pass;

  assign load_ready = (state == S_IDLE);
  assign rd_data    = ({1'b0, rd_addr} < DEPTH_L) ? grid[rd_addr] : '0;
  assign cur_row    = grid[row_ptr];
  // The grid below row_ptr is already rewritten this pass; row_ptr+1 is still pristine.
  assign next_row   = (row_ptr == LAST_ROW) ? '0 : grid[row_ptr + 1'b1];

  always_comb begin
    prev_pad = {1'b0, prev_row, 1'b0};
    cur_pad  = {1'b0, cur_row, 1'b0};
    next_pad = {1'b0, next_row, 1'b0};
    removed  = '0;
    row_pop  = '0;
    cnt      = '0;
    for (int j = 0; j < WIDTH; j++) begin
      cnt = {3'b0, cur_pad[j]} + {3'b0, cur_pad[j+2]};
      for (int d = 0; d < 3; d++) begin
        cnt = cnt + {3'b0, prev_pad[j+d]} + {3'b0, next_pad[j+d]};
      end
      removed[j] = cur_row[j] && (cnt < TH);
      row_pop    = row_pop + CW'(removed[j]);
    end
    new_row   = cur_row & ~removed;
    acc_total = acc + row_pop;
    last_pass = ((pass_count + 1'b1) == MAXP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) grid[i] <= '0;
      wr_ptr        <= '0;
      row_ptr       <= '0;
      prev_row      <= '0;
      acc           <= '0;
      sp_latched    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      limit_hit     <= 1'b0;
      pass_removed  <= '0;
      total_removed <= '0;
      pass_count    <= '0;
    end else if (clear) begin
      state         <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) grid[i] <= '0;
      wr_ptr        <= '0;
      row_ptr       <= '0;
      prev_row      <= '0;
      acc           <= '0;
      sp_latched    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      limit_hit     <= 1'b0;
      pass_removed  <= '0;
      total_removed <= '0;
      pass_count    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_valid) begin
            grid[wr_ptr] <= load_row;
            if (wr_ptr == LAST_ROW) begin
              wr_ptr <= '0;
              state  <= S_READY;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        S_READY: begin
          if (start) begin
            sp_latched    <= single_pass;
            total_removed <= '0;
            pass_count    <= '0;
            pass_removed  <= '0;
            limit_hit     <= 1'b0;
            acc           <= '0;
            row_ptr       <= '0;
            prev_row      <= '0;
            busy          <= 1'b1;
            state         <= S_SWEEP;
          end
        end
        S_SWEEP: begin
          grid[row_ptr] <= new_row;
          prev_row      <= cur_row;
          total_removed <= total_removed + row_pop;
          if (row_ptr == LAST_ROW) begin
            pass_count   <= pass_count + 1'b1;
            pass_removed <= acc_total;
            acc          <= '0;
            row_ptr      <= '0;
            prev_row     <= '0;
            if ((acc_total == '0) || sp_latched || last_pass) begin
              busy      <= 1'b0;
              limit_hit <= !sp_latched && (acc_total != '0) && last_pass;
              state     <= S_DONE;
            end
          end else begin
            row_ptr <= row_ptr + 1'b1;
            acc     <= acc_total;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_READY;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_grid_erosion_engine.sv
`default_nettype none
// Directed bench for grid_erosion_engine on a 3x3 grid; a second instance
// with MAX_PASSES=2 shares all inputs to exercise the pass limit.
module tb_grid_erosion_engine;
  localparam int W  = 3;
  localparam int D  = 3;
  localparam int CW = $clog2(W*D+1);

  logic clk = 1'b0, rst_n = 1'b0;
  logic load_valid = 1'b0, start = 1'b0, single_pass = 1'b0, clear = 1'b0;
  logic [W-1:0] load_row = '0;
  logic [1:0]   rd_addr  = '0;

  logic load_ready, busy, done, limit_hit;
  logic [CW-1:0] pass_removed, total_removed;
  logic [7:0]    pass_count;
  logic [W-1:0]  rd_data;
  logic load_ready2, busy2, done2, limit_hit2;
  logic [CW-1:0] pass_removed2, total_removed2;
  logic [1:0]    pass_count2;
  logic [W-1:0]  rd_data2;

  int compared = 0, mismatched = 0;
  int k1, k2;
  logic [W-1:0] r_a, r_b;

  grid_erosion_engine #(.WIDTH(W), .DEPTH(D), .THRESH(4), .MAX_PASSES(255)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_row(load_row), .start(start), .single_pass(single_pass), .clear(clear),
    .busy(busy), .done(done), .limit_hit(limit_hit), .pass_removed(pass_removed),
    .total_removed(total_removed), .pass_count(pass_count), .rd_addr(rd_addr),
    .rd_data(rd_data));

  grid_erosion_engine #(.WIDTH(W), .DEPTH(D), .THRESH(4), .MAX_PASSES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready2),
    .load_row(load_row), .start(start), .single_pass(single_pass), .clear(clear),
    .busy(busy2), .done(done2), .limit_hit(limit_hit2), .pass_removed(pass_removed2),
    .total_removed(total_removed2), .pass_count(pass_count2), .rd_addr(rd_addr),
    .rd_data(rd_data2));

  always #5 clk = ~clk;

  task tick();
    @(posedge clk);
    #1;
  endtask

  task load(input logic [8:0] g, input int n);
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_row   = g[i*3 +: 3];
      tick();
    end
    load_valid = 1'b0;
  endtask

  task do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task do_start(input logic sp);
    start       = 1'b1;
    single_pass = sp;
    tick();
    start       = 1'b0;
  endtask

  // k counts edges after the start edge T; records first edge after which done is high.
  task run(input int k0, output int d1, output int d2);
    d1 = 0;
    d2 = 0;
    for (int k = k0; k <= 30; k++) begin
      tick();
      if (done  && d1 == 0) d1 = k;
      if (done2 && d2 == 0) d2 = k;
    end
  endtask

  task read_row(input int r, output logic [W-1:0] a, output logic [W-1:0] b);
    rd_addr = 2'(r);
    #1;
    a = rd_data;
    b = rd_data2;
  endtask

  task test_reset();
    compared++; if (load_ready !== 1'b1) begin mismatched++; $display("FAIL reset_load_ready: got %0b want 1", load_ready); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %0b want 0", busy); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %0b want 0", done); end
    compared++; if (limit_hit !== 1'b0) begin mismatched++; $display("FAIL reset_limit_hit: got %0b want 0", limit_hit); end
    compared++; if (total_removed !== '0) begin mismatched++; $display("FAIL reset_total: got %0d want 0", total_removed); end
    compared++; if (pass_count !== '0) begin mismatched++; $display("FAIL reset_pass_count: got %0d want 0", pass_count); end
    compared++; if (pass_removed !== '0) begin mismatched++; $display("FAIL reset_pass_removed: got %0d want 0", pass_removed); end
    read_row(1, r_a, r_b);
    compared++; if (r_a !== 3'b000) begin mismatched++; $display("FAIL reset_rd_data: got %b want 000", r_a); end
  endtask

  task test_single_pass();
    load(9'h1FF, 3);
    compared++; if (load_ready !== 1'b0) begin mismatched++; $display("FAIL loaded_ready: got %0b want 0", load_ready); end
    do_start(1'b1);
    single_pass = 1'b0;
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL sp_busy: got %0b want 1", busy); end
    tick();
    compared++; if (total_removed !== 4'd2) begin mismatched++; $display("FAIL sp_total_row0: got %0d want 2", total_removed); end
    compared++; if (pass_removed !== 4'd0) begin mismatched++; $display("FAIL sp_pass_removed_mid: got %0d want 0", pass_removed); end
    run(2, k1, k2);
    compared++; if (k1 != 4) begin mismatched++; $display("FAIL sp_done_edge: got %0d want 4", k1); end
    compared++; if (total_removed !== 4'd4) begin mismatched++; $display("FAIL sp_total: got %0d want 4", total_removed); end
    compared++; if (pass_count !== 8'd1) begin mismatched++; $display("FAIL sp_pass_count: got %0d want 1", pass_count); end
    compared++; if (pass_removed !== 4'd4) begin mismatched++; $display("FAIL sp_pass_removed: got %0d want 4", pass_removed); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL sp_busy_end: got %0b want 0", busy); end
    read_row(1, r_a, r_b);
    compared++; if (r_a !== 3'b111) begin mismatched++; $display("FAIL sp_row1: got %b want 111", r_a); end
    read_row(0, r_a, r_b);
    compared++; if (r_a !== 3'b010) begin mismatched++; $display("FAIL sp_row0: got %b want 010", r_a); end
  endtask

  task test_exhaustive();
    do_clear();
    load(9'h1FF, 3);
    do_start(1'b0);
    run(1, k1, k2);
    compared++; if (k1 != 13) begin mismatched++; $display("FAIL ex_done_edge: got %0d want 13", k1); end
    compared++; if (total_removed !== 4'd9) begin mismatched++; $display("FAIL ex_total: got %0d want 9", total_removed); end
    compared++; if (pass_count !== 8'd4) begin mismatched++; $display("FAIL ex_pass_count: got %0d want 4", pass_count); end
    compared++; if (pass_removed !== 4'd0) begin mismatched++; $display("FAIL ex_pass_removed: got %0d want 0", pass_removed); end
    compared++; if (limit_hit !== 1'b0) begin mismatched++; $display("FAIL ex_limit_hit: got %0b want 0", limit_hit); end
    for (int r = 0; r < D; r++) begin
      read_row(r, r_a, r_b);
      compared++; if (r_a !== 3'b000) begin mismatched++; $display("FAIL ex_row%0d: got %b want 000", r, r_a); end
    end
    compared++; if (k2 != 7) begin mismatched++; $display("FAIL lim_done_edge: got %0d want 7", k2); end
    compared++; if (total_removed2 !== 4'd8) begin mismatched++; $display("FAIL lim_total: got %0d want 8", total_removed2); end
    compared++; if (pass_count2 !== 2'd2) begin mismatched++; $display("FAIL lim_pass_count: got %0d want 2", pass_count2); end
    compared++; if (pass_removed2 !== 4'd4) begin mismatched++; $display("FAIL lim_pass_removed: got %0d want 4", pass_removed2); end
    compared++; if (limit_hit2 !== 1'b1) begin mismatched++; $display("FAIL lim_limit_hit: got %0b want 1", limit_hit2); end
    read_row(1, r_a, r_b);
    compared++; if (r_b !== 3'b010) begin mismatched++; $display("FAIL lim_row1: got %b want 010", r_b); end
    read_row(0, r_a, r_b);
    compared++; if (r_b !== 3'b000) begin mismatched++; $display("FAIL lim_row0: got %b want 000", r_b); end
  endtask

  task test_empty();
    do_clear();
    load(9'h000, 3);
    for (int n = 0; n < 2; n++) begin
      do_start(1'b0);
      run(1, k1, k2);
      compared++; if (k1 != 4) begin mismatched++; $display("FAIL empty%0d_done_edge: got %0d want 4", n, k1); end
      compared++; if (total_removed !== 4'd0) begin mismatched++; $display("FAIL empty%0d_total: got %0d want 0", n, total_removed); end
      compared++; if (pass_count !== 8'd1) begin mismatched++; $display("FAIL empty%0d_pass_count: got %0d want 1", n, pass_count); end
      compared++; if (limit_hit !== 1'b0) begin mismatched++; $display("FAIL empty%0d_limit_hit: got %0b want 0", n, limit_hit); end
    end
  endtask

  task test_ignored_start();
    do_clear();
    load(9'h1FF, 2);
    compared++; if (load_ready !== 1'b1) begin mismatched++; $display("FAIL partial_load_ready: got %0b want 1", load_ready); end
    do_start(1'b1);
    tick();
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL ignored_start_busy: got %0b want 0", busy); end
    do_clear();
    compared++; if (load_ready !== 1'b1) begin mismatched++; $display("FAIL clear_load_ready: got %0b want 1", load_ready); end
    for (int r = 0; r < D; r++) begin
      read_row(r, r_a, r_b);
      compared++; if (r_a !== 3'b000) begin mismatched++; $display("FAIL clear_row%0d: got %b want 000", r, r_a); end
    end
    load(9'o305, 3);
    compared++; if (load_ready !== 1'b0) begin mismatched++; $display("FAIL reload_ready: got %0b want 0", load_ready); end
    read_row(0, r_a, r_b);
    compared++; if (r_a !== 3'b101) begin mismatched++; $display("FAIL reload_row0: got %b want 101", r_a); end
    read_row(2, r_a, r_b);
    compared++; if (r_a !== 3'b011) begin mismatched++; $display("FAIL reload_row2: got %b want 011", r_a); end
  endtask

  task test_reset_mid();
    do_clear();
    load(9'h1FF, 3);
    do_start(1'b0);
    repeat (4) tick();
    compared++; if (pass_count !== 8'd1) begin mismatched++; $display("FAIL mid_pass_count_pre: got %0d want 1", pass_count); end
    #2;
    rst_n = 1'b0;
    #1;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rstmid_busy: got %0b want 0", busy); end
    compared++; if (total_removed !== 4'd0) begin mismatched++; $display("FAIL rstmid_total: got %0d want 0", total_removed); end
    compared++; if (pass_count !== 8'd0) begin mismatched++; $display("FAIL rstmid_pass_count: got %0d want 0", pass_count); end
    compared++; if (pass_removed !== 4'd0) begin mismatched++; $display("FAIL rstmid_pass_removed: got %0d want 0", pass_removed); end
    compared++; if (load_ready !== 1'b1) begin mismatched++; $display("FAIL rstmid_load_ready: got %0b want 1", load_ready); end
    read_row(1, r_a, r_b);
    compared++; if (r_a !== 3'b000) begin mismatched++; $display("FAIL rstmid_row1: got %b want 000", r_a); end
    #1;
    rst_n = 1'b1;
    tick();
    do_start(1'b0);
    tick();
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rstmid_start_ignored: got %0b want 0", busy); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    tick();
    test_single_pass();
    test_exhaustive();
    test_empty();
    test_ignored_start();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
